i2s_serializer: RTL and testbench

- Downstream neighbour of the volume-scaling DAC stage, between it and the WM8731 codec pins.
- Generates bit clock and left/right clock from the system clock and shifts each 32-bit stereo word (left in [31:16], right in [15:0]) out serially, MSB first.
- Pulses AUD_DATA_OVER once per frame so the upstream stage can refresh the word before the next frame boundary.
- Runs only while codec initialisation reports finished.

---
 rtl/i2s_serializer.sv | 104 ++++++++++
 tb/tb_i2s_serializer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_serializer.sv
// i2s_serializer: BCLK/LRCK generation and MSB-first serial shift of 32-bit stereo words to the codec.
// Define AUD_I2S_FORMAT_EN for Philips I2S framing (MSB one BCLK after LRCK); default is left-justified.
module i2s_serializer #(
    parameter int CLK_DIV     = 8,
    parameter int SAMPLE_BITS = 16,
    parameter int SLOT_BITS   = 32
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     AUD_INIT_FINISH,
    input  logic [2*SAMPLE_BITS-1:0] DACDATA,
    output logic                     AUD_DATA_OVER,
    output logic                     AUD_BCLK,
    output logic                     AUD_DACLRCK,
    output logic                     AUD_DACDAT
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(2 * SLOT_BITS);
`ifdef AUD_I2S_FORMAT_EN
    localparam int OFS = 1;
`else
    localparam int OFS = 0;
`endif
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_BITS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                   state, state_nxt;
    logic [DW-1:0]            div_cnt, div_nxt;
    logic [BW-1:0]            bit_cnt, bit_nxt, nb;
    logic [2*SAMPLE_BITS-1:0] frame, frame_nxt, word;
    logic                     loaded, load, tick, fall, upd;
    logic                     bclk_nxt, lrck_nxt, dat_nxt, over_nxt;

    // serial bit for absolute frame position b, with the format offset applied within each slot
    function automatic logic slot_bit(input logic [BW-1:0] b, input logic [2*SAMPLE_BITS-1:0] w);
        int bi, p, d;
        logic [2*SAMPLE_BITS-1:0] sh;
        bi = int'(b);
        p  = bi >= SLOT_BITS ? bi - SLOT_BITS : bi;
        d  = p - OFS;
        sh = w >> ((bi >= SLOT_BITS ? 0 : SAMPLE_BITS) + SAMPLE_BITS - 1 - d);
        return d >= 0 && d < SAMPLE_BITS && sh[0];
    endfunction

    always_comb begin
        state_nxt = IDLE;
        div_nxt   = '0;
        bit_nxt   = '0;
        nb        = '0;
        bclk_nxt  = 1'b0;
        lrck_nxt  = 1'b0;
        dat_nxt   = 1'b0;
        over_nxt  = 1'b0;
        tick      = 1'b0;
        fall      = 1'b0;
        load      = 1'b0;
        upd       = 1'b0;
        word      = frame;
        frame_nxt = frame;
        if (AUD_INIT_FINISH) begin
            state_nxt = RUN;
            tick      = state == RUN && div_cnt == DIV_LAST;
            fall      = tick && AUD_BCLK;
            nb        = state == IDLE ? '0 : fall ? (bit_cnt == BIT_LAST ? '0 : bit_cnt + 1'b1) : bit_cnt;
            // RUN entry behaves like a falling edge that lands on bit 0 with a fresh load
            load      = state == IDLE || (fall && nb == '0);
            upd       = state == IDLE || fall;
            word      = load ? DACDATA : frame;
            frame_nxt = word;
            div_nxt   = state == RUN && !tick ? div_cnt + 1'b1 : '0;
            bit_nxt   = nb;
            bclk_nxt  = state == RUN && (AUD_BCLK ^ tick);
            lrck_nxt  = upd ? int'(nb) >= SLOT_BITS : AUD_DACLRCK;
            dat_nxt   = upd ? slot_bit(nb, word) : AUD_DACDAT;
            over_nxt  = loaded;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= IDLE;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            frame         <= '0;
            loaded        <= 1'b0;
            AUD_DATA_OVER <= 1'b0;
            AUD_BCLK      <= 1'b0;
            AUD_DACLRCK   <= 1'b0;
            AUD_DACDAT    <= 1'b0;
        end else begin
            state         <= state_nxt;
            div_cnt       <= div_nxt;
            bit_cnt       <= bit_nxt;
            frame         <= frame_nxt;
            loaded        <= load;
            AUD_DATA_OVER <= over_nxt;
            AUD_BCLK      <= bclk_nxt;
            AUD_DACLRCK   <= lrck_nxt;
            AUD_DACDAT    <= dat_nxt;
        end
    end
endmodule

// File: tb/tb_i2s_serializer.sv
// tb_i2s_serializer: randomized frames checked bit-by-bit on BCLK rises against a per-frame reference model.
module tb_i2s_serializer;
    localparam int CLK_DIV = 8;
    localparam int SB      = 16;
    localparam int SLOT    = 32;
    localparam int FRAME   = 4 * SLOT * CLK_DIV;
`ifdef AUD_I2S_FORMAT_EN
    localparam int OFS = 1;
`else
    localparam int OFS = 0;
`endif

    typedef struct packed {
        logic dat;
        logic lrck;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        AUD_INIT_FINISH = 1'b0;
    logic [31:0] DACDATA = '0;
    logic        AUD_DATA_OVER, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   nbits = 0;

    i2s_serializer dut (
        .CLK(CLK),
        .RESET(RESET),
        .AUD_INIT_FINISH(AUD_INIT_FINISH),
        .DACDATA(DACDATA),
        .AUD_DATA_OVER(AUD_DATA_OVER),
        .AUD_BCLK(AUD_BCLK),
        .AUD_DACLRCK(AUD_DACLRCK),
        .AUD_DACDAT(AUD_DACDAT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // bit k (0..63) of a frame as the codec should sample it
    function automatic logic ref_bit(input logic [31:0] w, input int k);
        logic [15:0] half;
        int d;
        half = k < SLOT ? w[31:16] : w[15:0];
        d = (k % SLOT) - OFS;
        if (d < 0 || d >= SB) return 1'b0;
        return half[SB-1-d];
    endfunction

    // producer: each load pulse enqueues the whole expected frame of the word being held
    initial begin
        int   last;
        logic prev;
        last = -1;
        prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (!AUD_INIT_FINISH || RESET) begin
                exp_q.delete();
                last = -1;
            end else if (AUD_DATA_OVER) begin
                total++;
                if (prev) begin
                    bad++;
                    $display("FAIL over_width: pulse high %0d consecutive cycles, required 1", 2);
                end
                if (last >= 0) begin
                    total++;
                    if (cyc - last != FRAME) begin
                        bad++;
                        $display("FAIL over_spacing: got %0d cycles, required %0d", cyc - last, FRAME);
                    end
                end
                last = cyc;
                for (int k = 0; k < 2 * SLOT; k++)
                    exp_q.push_back('{dat: ref_bit(DACDATA, k), lrck: (k >= SLOT)});
            end
            prev = AUD_DATA_OVER;
        end
    end

    // monitor: compare line state at every BCLK rise
    initial begin
        logic pb;
        exp_t e;
        pb = 1'b0;
        forever begin
            @(negedge CLK);
            if (AUD_INIT_FINISH && !RESET && AUD_BCLK && !pb) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL bit_unexpected: rise at cycle %0d with no frame queued", cyc);
                end else begin
                    e = exp_q.pop_front();
                    nbits++;
                    if ({AUD_DACDAT, AUD_DACLRCK} !== {e.dat, e.lrck}) begin
                        bad++;
                        $display("FAIL serial_bit: cycle %0d got dat=%b lrck=%b required dat=%b lrck=%b",
                                 cyc, AUD_DACDAT, AUD_DACLRCK, e.dat, e.lrck);
                    end
                end
            end
            pb = AUD_BCLK;
        end
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic wait_pulse(output int lat);
        int got;
        got = 0;
        lat = 0;
        for (int i = 0; i < FRAME + 80; i++) begin
            tick(1);
            lat++;
            if (AUD_DATA_OVER) begin
                got = 1;
                break;
            end
        end
        check("pulse_wait", got, 1);
    endtask

    task automatic quiet(input string name, input int n);
        int nz;
        nz = 0;
        repeat (n) begin
            tick(1);
            if ({AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, AUD_DATA_OVER} != 4'b0) nz++;
        end
        check(name, nz, 0);
    endtask

    initial begin
        int   lat, n, hi_l, hi_b;
        logic p;
        tick(3);
        check("reset_state", int'({AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, AUD_DATA_OVER}), 0);
        RESET = 1'b0;
        quiet("idle_quiet", 5000);

        DACDATA = 32'hA5A5_3C3C;
        AUD_INIT_FINISH = 1'b1;
        wait_pulse(lat);
        check("start_latency", lat, 2);
        tick(2);
        DACDATA = 32'hFFFF_FFFF;
        wait_pulse(lat);
        tick(300);
        DACDATA = 32'h0000_0000;
        wait_pulse(lat);
        for (int i = 0; i < 6; i++) begin
            tick($urandom_range(2, 1000));
            DACDATA = $urandom;
            wait_pulse(lat);
        end

        p = AUD_BCLK;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (AUD_BCLK && !p) break;
            p = AUD_BCLK;
        end
        p = 1'b1;
        for (n = 1; n <= 40; n++) begin
            tick(1);
            if (AUD_BCLK && !p) break;
            p = AUD_BCLK;
        end
        check("bclk_period", n, 2 * CLK_DIV);
        hi_l = 0;
        hi_b = 0;
        repeat (FRAME) begin
            tick(1);
            hi_l += int'(AUD_DACLRCK);
            hi_b += int'(AUD_BCLK);
        end
        check("lrck_high", hi_l, FRAME / 2);
        check("bclk_high", hi_b, FRAME / 2);

        // drop enable around bit 40, then restart
        wait_pulse(lat);
        tick(40 * 2 * CLK_DIV - 1);
        AUD_INIT_FINISH = 1'b0;
        tick(1);
        check("drop_next_edge", int'({AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, AUD_DATA_OVER}), 0);
        quiet("drop_quiet", 99);
        DACDATA = $urandom;
        AUD_INIT_FINISH = 1'b1;
        wait_pulse(lat);
        check("restart_latency", lat, 2);
        wait_pulse(lat);

        // same disruption through reset
        tick(40 * 2 * CLK_DIV - 1);
        RESET = 1'b1;
        tick(1);
        check("reset_next_edge", int'({AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, AUD_DATA_OVER}), 0);
        quiet("reset_quiet", 99);
        DACDATA = $urandom;
        RESET = 1'b0;
        wait_pulse(lat);
        check("reset_restart_latency", lat, 2);
        wait_pulse(lat);

        check("bits_checked", int'(nbits >= 64 * 10), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
